spi_rgb_cmd: RTL and testbench

- Command decoder and PWM driver between the SPI slave byte interface (ESP32 side) and the RGB LED wrapper.
- Parses framed command bytes into RGB duty registers and a test-mode flag, and generates glitch-free per-channel PWM for the wrapper's in_r/in_g/in_b inputs.
- Also supplies a readback byte for the SPI MISO path, so the ESP32 can read current state.

---
 rtl/spi_rgb_cmd.sv | 134 +++++++++++++
 tb/tb_spi_rgb_cmd.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rgb_cmd.sv
// rtl/spi_rgb_cmd.sv - SPI command decoder with RGB duty registers, readback and PWM generation
module spi_rgb_cmd #(
    parameter int unsigned PRESCALE      = 1,
    parameter bit          TEST_MODE_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_stb,
    input  logic       rx_first,
    input  logic       rx_last,
    output logic [7:0] tx_data,
    output logic       test_mode,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);

    typedef enum logic [2:0] {IDLE, WR_R, WR_G, WR_B, WR_MODE, RD, IGNORE} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    state_t     state;
    logic [7:0] duty_r, duty_g, duty_b;
    logic [7:0] stage_r, stage_g;
    logic [7:0] act_r, act_g, act_b;
    logic [7:0] cnt;
    logic [15:0] presc;
    logic [2:0] rd_idx;
    logic [2:0] rd_next;
    logic       tick;

    assign rd_next = (rd_idx >= 3'd4) ? 3'd4 : rd_idx + 3'd1;
    assign tick    = (presc == PRESC_MAX);

    function automatic logic [7:0] rd_sel(input logic [2:0] idx);
        case (idx)
            3'd0:    rd_sel = duty_r;
            3'd1:    rd_sel = duty_g;
            3'd2:    rd_sel = duty_b;
            3'd3:    rd_sel = {7'b0, test_mode};
            default: rd_sel = 8'h00;
        endcase
    endfunction

    // A first-of-frame strobe always resynchronises, whatever state we are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty_r    <= 8'h00;
            duty_g    <= 8'h00;
            duty_b    <= 8'h00;
            stage_r   <= 8'h00;
            stage_g   <= 8'h00;
            rd_idx    <= 3'd0;
            tx_data   <= 8'h00;
            test_mode <= TEST_MODE_RST;
        end else begin
            if (rx_stb && rx_first) begin
                case (rx_data)
                    8'h10:   state <= WR_R;
                    8'h11:   state <= WR_MODE;
                    8'h12: begin
                        state  <= RD;
                        rd_idx <= 3'd0;
                    end
                    default: state <= IGNORE;
                endcase
                tx_data <= (rx_data == 8'h12) ? duty_r : 8'h00;
            end else if (rx_stb) begin
                tx_data <= 8'h00;
                case (state)
                    WR_R: begin
                        stage_r <= rx_data;
                        state   <= WR_G;
                    end
                    WR_G: begin
                        stage_g <= rx_data;
                        state   <= WR_B;
                    end
                    WR_B: begin
                        duty_r <= stage_r;
                        duty_g <= stage_g;
                        duty_b <= rx_data;
                        state  <= IGNORE;
                    end
                    WR_MODE: begin
                        test_mode <= rx_data[0];
                        state     <= IGNORE;
                    end
                    RD: begin
                        rd_idx  <= rd_next;
                        tx_data <= rd_sel(rd_next);
                    end
                    default: ;
                endcase
            end
            if (rx_last) begin
                state   <= IDLE;
                tx_data <= 8'h00;
            end
        end
    end

    // Active duties only reload on the wrap to 0 so each period sees one value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= 16'd0;
            cnt   <= 8'd0;
            act_r <= 8'h00;
            act_g <= 8'h00;
            act_b <= 8'h00;
            pwm_r <= 1'b0;
            pwm_g <= 1'b0;
            pwm_b <= 1'b0;
        end else begin
            if (tick) begin
                presc <= 16'd0;
                cnt   <= cnt + 8'd1;
                if (cnt == 8'hFF) begin
                    act_r <= duty_r;
                    act_g <= duty_g;
                    act_b <= duty_b;
                end
            end else begin
                presc <= presc + 16'd1;
            end
            pwm_r <= (cnt < act_r);
            pwm_g <= (cnt < act_g);
            pwm_b <= (cnt < act_b);
        end
    end

endmodule

// File: tb/tb_spi_rgb_cmd.sv
// tb/tb_spi_rgb_cmd.sv - scoreboard bench for spi_rgb_cmd against a frame-level reference model
module tb_spi_rgb_cmd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_stb = 1'b0;
    logic       rx_first = 1'b0;
    logic       rx_last = 1'b0;
    logic [7:0] tx_data;
    logic       test_mode;
    logic       pwm_r, pwm_g, pwm_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic       stb_q = 1'b0;

    logic [7:0] m_duty[3];
    logic       m_mode;
    logic [7:0] seg[$];
    bit         in_frame;

    spi_rgb_cmd #(.PRESCALE(1), .TEST_MODE_RST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_stb(rx_stb),
        .rx_first(rx_first), .rx_last(rx_last), .tx_data(tx_data),
        .test_mode(test_mode), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_duty[0] = 8'h00;
        m_duty[1] = 8'h00;
        m_duty[2] = 8'h00;
        m_mode    = 1'b1;
        in_frame  = 0;
        seg.delete();
    endfunction

    // Frame-level semantics: a segment starts at rx_first; the readback
    // list is duty r,g,b, mode, then zeros.
    function automatic logic [7:0] model_byte(input logic [7:0] d, input bit first);
        int k;
        logic [7:0] rb[5];
        if (first) begin
            seg.delete();
            seg.push_back(d);
            in_frame = 1;
        end else if (in_frame) begin
            seg.push_back(d);
        end else begin
            return 8'h00;
        end
        k = seg.size() - 1;
        if (seg[0] == 8'h10 && k == 3) begin
            m_duty[0] = seg[1];
            m_duty[1] = seg[2];
            m_duty[2] = seg[3];
        end
        if (seg[0] == 8'h11 && k == 1) m_mode = d[0];
        if (seg[0] == 8'h12) begin
            rb[0] = m_duty[0];
            rb[1] = m_duty[1];
            rb[2] = m_duty[2];
            rb[3] = {7'b0, m_mode};
            rb[4] = 8'h00;
            return rb[(k > 4) ? 4 : k];
        end
        return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit first, input bit last);
        logic [7:0] e;
        @(negedge clk);
        rx_data  = d;
        rx_stb   = 1'b1;
        rx_first = first;
        rx_last  = last;
        e = model_byte(d, first);
        exp_q.push_back(last ? 8'h00 : e);
        if (last) in_frame = 0;
        @(negedge clk);
        rx_stb   = 1'b0;
        rx_first = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        rx_last = 1'b1;
        @(negedge clk);
        rx_last = 1'b0;
        in_frame = 0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit coinc_last);
        for (int i = 0; i < bytes.size(); i++)
            send_byte(bytes[i], i == 0, coinc_last && (i == bytes.size() - 1));
        if (!coinc_last) end_frame();
    endtask

    task automatic pwm_check(input string tag);
        int hr, hg, hb;
        hr = 0; hg = 0; hb = 0;
        repeat (600) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
        end
        check({tag, " pwm_r highs"}, hr, int'(m_duty[0]));
        check({tag, " pwm_g highs"}, hg, int'(m_duty[1]));
        check({tag, " pwm_b highs"}, hb, int'(m_duty[2]));
        check({tag, " test_mode"}, int'(test_mode), int'(m_mode));
        check({tag, " tx idle"}, int'(tx_data), 0);
    endtask

    always @(posedge clk) stb_q <= rx_stb;

    always @(negedge clk) begin
        if (stb_q) begin
            if (exp_q.size() == 0) begin
                check("tx scoreboard underflow", int'(tx_data), -1);
            end else begin
                check("tx_data after strobe", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [7:0] fr[$];
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (pwm_r || pwm_g || pwm_b || tx_data != 8'h00 || test_mode != 1'b1) bad++;
        end
        check("reset idle cycles off", bad, 0);

        fr = '{8'h10, 8'h40, 8'h80, 8'hFF};
        send_frame(fr, 1);
        pwm_check("write");

        fr = '{8'h10, 8'h11, 8'h22};
        send_frame(fr, 0);
        fr = '{8'h11, 8'h00};
        send_frame(fr, 0);
        pwm_check("partial+mode");

        fr = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);

        send_byte(8'h10, 1, 0);
        send_byte(8'hAA, 0, 0);
        send_byte(8'hBB, 0, 0);
        fr = '{8'h10, 8'h01, 8'h02, 8'h03};
        send_frame(fr, 0);
        fr = '{8'h7E, 8'h55, 8'h66, 8'h77};
        send_frame(fr, 0);
        pwm_check("resync");

        send_byte(8'h10, 1, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h33, 0, 0);
        end_frame();
        pwm_check("reset mid-write");

        for (int f = 0; f < 30; f++) begin
            int r, n;
            bit co;
            r = $urandom_range(0, 3);
            n = $urandom_range(0, 6);
            co = ($urandom_range(0, 1) == 1) && (n > 0);
            case (r)
                0: send_byte(8'h10, 1, 0);
                1: send_byte(8'h11, 1, 0);
                2: send_byte(8'h12, 1, 0);
                default: send_byte(8'($urandom), 1, 0);
            endcase
            for (int i = 0; i < n; i++) begin
                send_byte(8'($urandom), 0, co && (i == n - 1));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if (!co) end_frame();
            if (f % 6 == 5) pwm_check("random");
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
